rsa_core_scheduler: RTL
=======================

// Module: rsa_core_scheduler
// PURPOSE
//  Command sequencer between the ARM command/data port and NUM_CORES RSA compute cores.
//  Decodes 32-bit ARM commands (READ, COMPUTE, WRITE) and routes the 1024-bit operand or
//  result to the core selected in the command. Sequences each core's load/start/done,
//  guards compute with a timeout, and returns one done/done_read handshake per command.
// PARAMETERS
//  NUM_CORES   2        number of attached cores (1..16)
//  DATA_W      1024     operand/result width
//  TIMEOUT     2**20    max cycles WAIT_CORE waits for core_done before abort
// PORTS
//  clk                     in   1              system clock, all logic on rising edge
//  resetn                  in   1              asynchronous active-low reset
//  arm_to_fpga_cmd         in   32             [1:0] opcode 0=READ 1=COMPUTE 2=WRITE; [11:8] core sel
//  arm_to_fpga_cmd_valid   in   1              command strobe, sampled only in IDLE
//  fpga_to_arm_done        out  1              command complete, held until done_read
//  fpga_to_arm_done_read   in   1              ARM acknowledge of done
//  arm_to_fpga_data_valid  in   1              inbound operand valid
//  arm_to_fpga_data_ready  out  1              high only in RX_DATA
//  arm_to_fpga_data        in   DATA_W         inbound operand
//  fpga_to_arm_data_valid  out  1              outbound result valid, high only in TX_DATA
//  fpga_to_arm_data_ready  in   1              ARM ready for result
//  fpga_to_arm_data        out  DATA_W         outbound result register
//  core_din                out  DATA_W         operand register broadcast to all cores
//  core_load               out  NUM_CORES      1-cycle load pulse, one-hot on sel
//  core_start              out  NUM_CORES      1-cycle start pulse, one-hot on sel
//  core_done               in   NUM_CORES      per-core completion level/pulse
//  core_dout               in   NUM_CORES*DATA_W  flattened core results, core i at [i*DATA_W +: DATA_W]
//  leds                    out  4              {err, done_pending, wait_core, busy}
// BEHAVIOUR
//  Reset: state=IDLE; every output, core_din, fpga_to_arm_data, err, sel, timeout cnt = 0.
//  States: IDLE, RX_DATA, LOAD, START, WAIT_CORE, TX_DATA, DONE.
//  IDLE: on cmd_valid latch opcode and sel, clear err. Next state:
//   sel>=NUM_CORES or opcode==3 -> err=1, DONE; READ -> RX_DATA; COMPUTE -> START;
//   WRITE -> TX_DATA and capture core_dout[sel] into fpga_to_arm_data in the same edge.
//  RX_DATA: ready=1 (decoded from state). On valid&ready, capture data into core_din -> LOAD.
//  LOAD: core_load[sel]=1 for exactly this cycle; core_din stable -> DONE.
//  START: core_start[sel]=1 for exactly this cycle; timeout cnt=0 -> WAIT_CORE.
//  WAIT_CORE: cnt increments each cycle. core_done[sel]=1 -> DONE (done wins over timeout
//   on the same cycle); else cnt==TIMEOUT-1 -> err=1, DONE. core_done of other cores ignored.
//  TX_DATA: valid=1, data held. On valid&ready -> DONE.
//  DONE: fpga_to_arm_done=1. On done_read -> IDLE (done low the next cycle).
//  Latency: COMPUTE start pulse 2 cycles after cmd_valid edge; done 1 cycle after core_done.
//  cmd_valid outside IDLE ignored, never queued. data_valid outside RX_DATA ignored.
//  done_read outside DONE ignored. err sticky until next accepted command.
//  Core results are not buffered: WRITE returns whatever core_dout[sel] holds at acceptance.
//  Async reset mid-command returns immediately to IDLE, drops all pulses/valids, discards
//   captured data; cores see no start pulse.
//  leds: busy = state!=IDLE; wait_core = WAIT_CORE; done_pending = DONE; err = err.
// TESTING
//  1 READ sel=1, data=0x0123456789abcdef<<640 -> ready high, core_load=2'b10 one cycle,
//    core_din matches, done high until done_read.
//  2 COMPUTE sel=0, model core_done[0] 50 cycles after start -> one start pulse 2'b01,
//    done 1 cycle after core_done, err=0.
//  3 WRITE sel=1, core_dout[1]=0xdeadbeef -> valid held through 20 cycles of ready=0,
//    data==0xdeadbeef on handshake, then done.
//  4 COMPUTE with TIMEOUT=16, core never done -> done after 16 WAIT cycles, leds[3]=1;
//    next valid READ clears err.
//  5 Invalid: opcode 3, then sel=5 -> each immediate done, err=1, no load/start pulses.
//  6 Reset asserted in WAIT_CORE and in TX_DATA -> all outputs 0, IDLE; a fresh READ
//    afterwards completes normally.

Source files
------------

// File: rtl/rsa_core_scheduler.sv
// rsa_core_scheduler
//   Command sequencer between the ARM command/data port and NUM_CORES RSA
//   compute cores. Decodes READ / COMPUTE / WRITE commands, moves a DATA_W
//   operand into the shared core input register or a core result out to the
//   ARM, pulses the selected core's load/start, guards compute with a timeout
//   and returns one done / done_read handshake per command.
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   arm_to_fpga_cmd[_valid]      command word ([1:0] opcode, [11:8] core sel)
//   fpga_to_arm_done[_read]      completion flag and its acknowledge
//   arm_to_fpga_data*            inbound operand handshake (ready in RX_DATA)
//   fpga_to_arm_data*            outbound result handshake (valid in TX_DATA)
//   core_din                     operand register broadcast to every core
//   core_load, core_start        one-cycle pulses, one-hot on the selected core
//   core_done, core_dout         per-core completion and flattened results
//   leds                         {err, done_pending, wait_core, busy}
module rsa_core_scheduler #(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned DATA_W    = 1024,
    parameter int unsigned TIMEOUT   = 2**20
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [31:0]                   arm_to_fpga_cmd,
    input  logic                          arm_to_fpga_cmd_valid,
    output logic                          fpga_to_arm_done,
    input  logic                          fpga_to_arm_done_read,
    input  logic                          arm_to_fpga_data_valid,
    output logic                          arm_to_fpga_data_ready,
    input  logic [DATA_W-1:0]             arm_to_fpga_data,
    output logic                          fpga_to_arm_data_valid,
    input  logic                          fpga_to_arm_data_ready,
    output logic [DATA_W-1:0]             fpga_to_arm_data,
    output logic [DATA_W-1:0]             core_din,
    output logic [NUM_CORES-1:0]          core_load,
    output logic [NUM_CORES-1:0]          core_start,
    input  logic [NUM_CORES-1:0]          core_done,
    input  logic [NUM_CORES*DATA_W-1:0]   core_dout,
    output logic [3:0]                    leds
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_DATA,
        S_LOAD,
        S_START,
        S_WAIT_CORE,
        S_TX_DATA,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [3:0]          r_sel;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_core_din;
    logic [DATA_W-1:0]   r_tx_data;

    logic [1:0]          w_cmd_op;
    logic [3:0]          w_cmd_sel;
    logic                w_cmd_sel_ok;
    logic [DATA_W-1:0]   w_cmd_dout;
    logic [NUM_CORES-1:0] w_sel_onehot;
    logic                w_sel_done;
    logic                w_unused_cmd_bits;

    assign w_cmd_op          = arm_to_fpga_cmd[1:0];
    assign w_cmd_sel         = arm_to_fpga_cmd[11:8];
    assign w_cmd_sel_ok      = (32'(w_cmd_sel) < NUM_CORES);
    assign w_unused_cmd_bits = ^{arm_to_fpga_cmd[31:12], arm_to_fpga_cmd[7:2]};

    // Result mux driven by the incoming command's sel so WRITE can capture
    // core_dout on the same edge the command is accepted.
    always_comb begin
        w_cmd_dout = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (w_cmd_sel == 4'(i)) begin
                w_cmd_dout = core_dout[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_sel_onehot = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            w_sel_onehot[i] = (r_sel == 4'(i));
        end
    end

    // Completion of any core other than the selected one is masked out.
    assign w_sel_done = |(core_done & w_sel_onehot);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_core_din <= '0;
            r_tx_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm_to_fpga_cmd_valid) begin
                        r_sel <= w_cmd_sel;
                        r_err <= 1'b0;
                        if (!w_cmd_sel_ok || (w_cmd_op == 2'd3)) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_cmd_op == 2'd0) begin
                            r_state <= S_RX_DATA;
                        end else if (w_cmd_op == 2'd1) begin
                            r_state <= S_START;
                        end else begin
                            r_tx_data <= w_cmd_dout;
                            r_state   <= S_TX_DATA;
                        end
                    end
                end
                S_RX_DATA: begin
                    if (arm_to_fpga_data_valid) begin
                        r_core_din <= arm_to_fpga_data;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_state <= S_DONE;
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_CORE;
                end
                S_WAIT_CORE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_sel_done) begin
                        r_state <= S_DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_TX_DATA: begin
                    if (fpga_to_arm_data_ready) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (fpga_to_arm_done_read) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign arm_to_fpga_data_ready = (r_state == S_RX_DATA);
    assign fpga_to_arm_data_valid = (r_state == S_TX_DATA);
    assign fpga_to_arm_done       = (r_state == S_DONE);
    assign fpga_to_arm_data       = r_tx_data;
    assign core_din               = r_core_din;
    assign core_load              = (r_state == S_LOAD)  ? w_sel_onehot : '0;
    assign core_start             = (r_state == S_START) ? w_sel_onehot : '0;
    assign leds = {r_err, (r_state == S_DONE), (r_state == S_WAIT_CORE), (r_state != S_IDLE)};

endmodule
